// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: bus widths, load opcodes,
// stall vector encoding and the load-wait FSM states.
package mem_stage_pkg;

  localparam int EX_TO_MEM_WD = 79;
  localparam int MEM_TO_WB_WD = 70;
  localparam int MEM_TO_ID_WD = 38;

  localparam int StallBus = 6;
  localparam logic Stop   = 1'b1;
  localparam logic NoStop = 1'b0;

  localparam logic [2:0] LW  = 3'b000;
  localparam logic [2:0] LB  = 3'b001;
  localparam logic [2:0] LBU = 3'b010;
  localparam logic [2:0] LH  = 3'b011;
  localparam logic [2:0] LHU = 3'b100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } mem_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [2:0]  ld_op;
    logic        ram_en;
    logic [3:0]  ram_wen;
    logic        sel_rf_res;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] result;
  } ex_mem_t;

endpackage

// File: rtl/mem_stage_load_align.sv
// Byte/halfword/word extraction and sign/zero extension of load data.
module load_align
  import mem_stage_pkg::*;
(
  input  logic [2:0]  ld_op,
  input  logic [1:0]  addr,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  logic [31:0] shifted;
  logic [7:0]  b;
  logic [15:0] h;

  assign shifted = rdata >> {addr, 3'b000};
  assign b = shifted[7:0];
  assign h = addr[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    data = rdata;
    unique case (1'b1)
      ld_op == LB:  data = {{24{b[7]}}, b};
      ld_op == LBU: data = {24'h0, b};
      ld_op == LH:  data = {{16{h[15]}}, h};
      ld_op == LHU: data = {16'h0, h};
      default:      data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: EX/MEM register, variable-latency load wait FSM,
// load alignment and WB / ID-forwarding bus generation.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [StallBus-1:0]     stall,
  input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  input  logic [31:0]             data_sram_rdata,
  input  logic                    data_sram_rvalid,
  output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
  output logic [MEM_TO_ID_WD-1:0] mem_to_id_bus,
  output logic                    stallreq_for_mem
);

  ex_mem_t    r;
  mem_state_e state;
  logic [31:0] ld_buf;
  logic        is_load;
  logic        rvalid;
  logic [31:0] ld_src;
  logic [31:0] ld_data;
  logic [31:0] rf_wdata;
  logic        rf_we;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r <= '0;
    end else if (stall[3] == Stop && stall[4] == NoStop) begin
      r <= '0;
    end else if (stall[3] == NoStop) begin
      r <= ex_mem_t'(ex_to_mem_bus);
    end
  end

  assign is_load = r.ram_en & (r.ram_wen == 4'b0000);
  assign rvalid  = data_sram_rvalid;

  // rdata is a one-cycle pulse: park it in ld_buf if MEM can't advance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      ld_buf <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (is_load && !rvalid) begin
            state <= WAIT;
          end else if (is_load && rvalid && stall[3] == Stop) begin
            state  <= HOLD;
            ld_buf <= data_sram_rdata;
          end
        end
        WAIT: begin
          if (rvalid && stall[3] == NoStop) begin
            state <= IDLE;
          end else if (rvalid) begin
            state  <= HOLD;
            ld_buf <= data_sram_rdata;
          end
        end
        HOLD: begin
          if (stall[3] == NoStop) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign stallreq_for_mem = is_load & ~rvalid & (state != HOLD);

  assign ld_src = (state == HOLD) ? ld_buf : data_sram_rdata;

  load_align u_align (
    .ld_op (r.ld_op),
    .addr  (r.result[1:0]),
    .rdata (ld_src),
    .data  (ld_data)
  );

  assign rf_wdata = r.sel_rf_res ? ld_data : r.result;
  assign rf_we    = r.rf_we & ~stallreq_for_mem;

  assign mem_to_wb_bus = {r.pc, rf_we, r.rf_waddr, rf_wdata};
  assign mem_to_id_bus = {rf_we, r.rf_waddr, rf_wdata};

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: loads of every width, wait states,
// stall/hold, bubbles, back-to-back loads and asynchronous reset.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  stall;
  logic [5:0]  stall_ext;
  logic [78:0] ex_bus;
  logic [31:0] rdata;
  logic        rvalid;
  logic [69:0] wb;
  logic [37:0] id;
  logic        sreq;

  int n_tests = 0;
  int n_fail  = 0;
  logic [69:0] sb[$];
  logic [69:0] exp;

  always #5 clk = ~clk;

  // stand-in hazard unit: a MEM stall request freezes stages 0..4
  assign stall = sreq ? 6'b011111 : stall_ext;

  mem_stage dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .stall            (stall),
    .ex_to_mem_bus    (ex_bus),
    .data_sram_rdata  (rdata),
    .data_sram_rvalid (rvalid),
    .mem_to_wb_bus    (wb),
    .mem_to_id_bus    (id),
    .stallreq_for_mem (sreq)
  );

  task automatic chk(input string tag, input logic [69:0] got,
                     input logic [69:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    rvalid = 1'b0;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  function automatic logic [78:0] mk(
    input logic [31:0] pc, input logic [2:0] op, input logic en,
    input logic [3:0] wen, input logic sel, input logic we,
    input logic [4:0] wa, input logic [31:0] res);
    return {pc, op, en, wen, sel, we, wa, res};
  endfunction

  function automatic logic [31:0] ref_ld(input logic [2:0] op,
                                         input logic [1:0] a,
                                         input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    case (a)
      2'd0:    b = d[7:0];
      2'd1:    b = d[15:8];
      2'd2:    b = d[23:16];
      default: b = d[31:24];
    endcase
    h = a[1] ? d[31:16] : d[15:0];
    case (op)
      3'd1:    return {{24{b[7]}}, b};
      3'd2:    return {24'h0, b};
      3'd3:    return {{16{h[15]}}, h};
      3'd4:    return {16'h0, h};
      default: return d;
    endcase
  endfunction

  task automatic drive_ld(input logic [31:0] pc, input logic [2:0] op,
                          input logic [31:0] addr, input logic [4:0] wa,
                          input logic [31:0] d);
    ex_bus = mk(pc, op, 1'b1, 4'h0, 1'b1, 1'b1, wa, addr);
    sb.push_back({pc, 1'b1, wa, ref_ld(op, addr[1:0], d)});
  endtask

  task automatic chk_pop(input string tag);
    exp = sb.pop_front();
    chk(tag, wb, exp);
    chk({tag, "_id"}, {32'h0, id}, {32'h0, exp[37:0]});
  endtask

  initial begin
    rst_n = 1'b0;
    stall_ext = '0;
    ex_bus = '0;
    rdata = '0;
    rvalid = 1'b0;

    smp();
    chk("rst_wb", wb, '0);
    chk("rst_id", {32'h0, id}, '0);
    chk("rst_sreq", {69'h0, sreq}, 70'h0);
    step();
    rst_n = 1'b1;

    // LB zero-wait, byte 3 sign-extended
    step();
    drive_ld(32'h100, 3'd1, 32'h1003, 5'd3, 32'h80FF_1234);
    step();
    ex_bus = '0;
    rvalid = 1'b1;
    rdata = 32'h80FF_1234;
    smp();
    chk("lb_sreq", {69'h0, sreq}, 70'h0);
    chk("lb_val", {38'h0, wb[31:0]}, {38'h0, 32'hFFFF_FF80});
    chk_pop("lb");

    // LHU with three wait cycles
    step();
    drive_ld(32'h200, 3'd4, 32'h2002, 5'd4, 32'h8765_4321);
    step();
    ex_bus = '0;
    for (int i = 0; i < 3; i++) begin
      smp();
      chk("lhu_sreq", {69'h0, sreq}, 70'h1);
      chk("lhu_id_we", {69'h0, id[37]}, 70'h0);
      step();
    end
    rvalid = 1'b1;
    rdata = 32'h8765_4321;
    smp();
    chk("lhu_sreq_done", {69'h0, sreq}, 70'h0);
    chk("lhu_val", {38'h0, wb[31:0]}, {38'h0, 32'h0000_8765});
    chk_pop("lhu");

    // LW with rvalid under a 2-cycle downstream stall
    step();
    drive_ld(32'h300, 3'd0, 32'h3000, 5'd6, 32'hDEAD_BEEF);
    step();
    ex_bus = '0;
    rvalid = 1'b1;
    rdata = 32'hDEAD_BEEF;
    stall_ext = 6'b011111;
    smp();
    chk("hold_c1", wb, sb[0]);
    chk("hold_c1_sreq", {69'h0, sreq}, 70'h0);
    step();
    rdata = 32'h1111_1111;
    smp();
    chk("hold_c2", wb, sb[0]);
    chk("hold_c2_sreq", {69'h0, sreq}, 70'h0);
    step();
    stall_ext = '0;
    ex_bus = mk(32'h400, 3'd0, 1'b0, 4'h0, 1'b0, 1'b1, 5'd7, 32'h55);
    smp();
    chk_pop("hold_release");

    // ALU passthrough, then bubble
    step();
    ex_bus = '0;
    stall_ext = 6'b001111;
    smp();
    chk("alu_x", wb, {32'h400, 1'b1, 5'd7, 32'h55});
    step();
    stall_ext = '0;
    ex_bus = mk(32'h500, 3'd0, 1'b0, 4'h0, 1'b0, 1'b1, 5'd5, 32'h1234);
    smp();
    chk("bubble", wb, '0);
    step();
    ex_bus = '0;
    smp();
    chk("alu_1234", wb, {32'h500, 1'b1, 5'd5, 32'h1234});

    // store: no FSM involvement, result passes through
    step();
    ex_bus = mk(32'h580, 3'd0, 1'b1, 4'hF, 1'b0, 1'b0, 5'd0, 32'h0000_2000);
    step();
    ex_bus = '0;
    smp();
    chk("store_sreq", {69'h0, sreq}, 70'h0);
    chk("store_wb", wb, {32'h580, 1'b0, 5'd0, 32'h0000_2000});

    // back-to-back LW then LBU, zero wait
    step();
    drive_ld(32'h600, 3'd0, 32'h0, 5'd8, 32'h0000_AB00);
    step();
    drive_ld(32'h604, 3'd2, 32'h1001, 5'd9, 32'h0000_AB00);
    rvalid = 1'b1;
    rdata = 32'h0000_AB00;
    smp();
    chk("b2b_lw_sreq", {69'h0, sreq}, 70'h0);
    chk("b2b_lw", {38'h0, wb[31:0]}, {38'h0, 32'h0000_AB00});
    chk_pop("b2b_lw_sb");
    step();
    ex_bus = '0;
    rvalid = 1'b1;
    rdata = 32'h0000_AB00;
    smp();
    chk("b2b_lbu_sreq", {69'h0, sreq}, 70'h0);
    chk("b2b_lbu", {38'h0, wb[31:0]}, {38'h0, 32'h0000_00AB});
    chk_pop("b2b_lbu_sb");

    // pseudo-random zero-wait loads across all opcodes
    for (int i = 0; i < 12; i++) begin
      logic [31:0] d;
      logic [2:0]  op;
      logic [31:0] a;
      d  = $urandom;
      op = 3'($urandom_range(7));
      a  = $urandom;
      step();
      drive_ld(32'h1000 + 32'(i * 4), op, a, 5'(i + 1), d);
      step();
      ex_bus = '0;
      rvalid = 1'b1;
      rdata = d;
      smp();
      chk_pop("rnd");
    end

    // stray rvalid with no load in the register
    step();
    rvalid = 1'b1;
    rdata = 32'hCAFE_F00D;
    smp();
    chk("stray_wb", wb, '0);
    chk("stray_sreq", {69'h0, sreq}, 70'h0);

    // asynchronous reset in the middle of a wait
    step();
    drive_ld(32'h700, 3'd1, 32'h7001, 5'd10, 32'h0);
    step();
    ex_bus = '0;
    smp();
    chk("wait_sreq", {69'h0, sreq}, 70'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_wb", wb, '0);
    chk("arst_id", {32'h0, id}, '0);
    chk("arst_sreq", {69'h0, sreq}, 70'h0);
    step();
    rst_n = 1'b1;
    step();
    rvalid = 1'b1;
    rdata = 32'h1234_5678;
    smp();
    chk("post_rst_wb", wb, '0);
    chk("post_rst_sreq", {69'h0, sreq}, 70'h0);
    void'(sb.pop_front());

    chk("sb_empty", 70'(sb.size()), 70'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
